// File: rtl/voice_phase_acc_if.sv
// ---------------------------------------------------------------------------
// voice_phase_acc_if
// Bus between the tuning-word demux / sequencer side and the two-voice DDS
// phase accumulator.
//   sample_tick  : one-cycle sample-rate pulse (may repeat on back-to-back cycles)
//   tw0, tw1     : per-voice tuning words (M bits)
//   tw_load      : per-voice load strobe, bit i captures tw_i
//   gate         : per-voice enable
//   wave_sel     : per-voice waveform, 0 = saw, 1 = square
//   sample_out   : mixed unsigned sample (W bits)
//   sample_valid : one-cycle pulse when sample_out is updated
//   wrap         : per-voice one-cycle pulse on accumulator carry-out
// master drives the control side, slave is the accumulator.
// ---------------------------------------------------------------------------
interface voice_phase_acc_if #(
   parameter int M = 12,
   parameter int W = 8
);
   logic         sample_tick;
   logic [M-1:0] tw0;
   logic [M-1:0] tw1;
   logic [1:0]   tw_load;
   logic [1:0]   gate;
   logic [1:0]   wave_sel;
   logic [W-1:0] sample_out;
   logic         sample_valid;
   logic [1:0]   wrap;

   modport master (
      output sample_tick, tw0, tw1, tw_load, gate, wave_sel,
      input  sample_out, sample_valid, wrap
   );

   modport slave (
      input  sample_tick, tw0, tw1, tw_load, gate, wave_sel,
      output sample_out, sample_valid, wrap
   );
endinterface

// File: rtl/voice_phase_acc.sv
// ---------------------------------------------------------------------------
// voice_phase_acc
// Two-voice DDS phase accumulator and mixer. Each voice latches its tuning
// word on a load strobe, advances its N-bit phase on every sample tick while
// gated, and yields a saw or square amplitude of W-1 bits. Both amplitudes
// are summed into one W-bit unsigned sample, two clocks after the tick.
// Ports:
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : voice_phase_acc_if.slave (tick, tuning words, load strobes,
//           gate, wave_sel in; sample_out, sample_valid, wrap out)
// ---------------------------------------------------------------------------
module voice_phase_acc #(
   parameter int M = 12,
   parameter int N = 16,
   parameter int W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   voice_phase_acc_if.slave bus
);

   localparam int A = W - 1;

   logic [M-1:0] tw_reg0;
   logic [M-1:0] tw_reg1;
   logic [N-1:0] acc0_p0;
   logic [N-1:0] acc1_p0;
   logic [1:0]   wrap_p0;
   logic         vld_p0;
   logic [W-1:0] sample_p1;
   logic         vld_p1;
   logic [N:0]   sum0;
   logic [N:0]   sum1;

   // Amplitude of one voice from its registered phase; gated-off voices are silent.
   function automatic logic [W-1:0] amp(input logic [N-1:0] acc,
                                        input logic         en,
                                        input logic         sq);
      logic [A-1:0] a;
      if (!en)
         a = '0;
      else if (sq)
         a = {A{acc[N-1]}};
      else
         a = acc[N-1 -: A];
      return {1'b0, a};
   endfunction

   // Carry lands in bit N; tuning word zero-extended to the phase width.
   assign sum0 = {1'b0, acc0_p0} + {{(N + 1 - M){1'b0}}, tw_reg0};
   assign sum1 = {1'b0, acc1_p0} + {{(N + 1 - M){1'b0}}, tw_reg1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tw_reg0   <= '0;
         tw_reg1   <= '0;
         acc0_p0   <= '0;
         acc1_p0   <= '0;
         wrap_p0   <= '0;
         vld_p0    <= 1'b0;
         sample_p1 <= '0;
         vld_p1    <= 1'b0;
      end else begin
         // Stage p0: tuning capture and phase accumulation. The accumulate
         // reads the old tuning word when a load coincides with a tick.
         if (bus.tw_load[0]) tw_reg0 <= bus.tw0;
         if (bus.tw_load[1]) tw_reg1 <= bus.tw1;

         if (!bus.gate[0]) begin
            acc0_p0    <= '0;
            wrap_p0[0] <= 1'b0;
         end else if (bus.sample_tick) begin
            acc0_p0    <= sum0[N-1:0];
            wrap_p0[0] <= sum0[N];
         end else begin
            wrap_p0[0] <= 1'b0;
         end

         if (!bus.gate[1]) begin
            acc1_p0    <= '0;
            wrap_p0[1] <= 1'b0;
         end else if (bus.sample_tick) begin
            acc1_p0    <= sum1[N-1:0];
            wrap_p0[1] <= sum1[N];
         end else begin
            wrap_p0[1] <= 1'b0;
         end

         vld_p0 <= bus.sample_tick;

         // Stage p1: amplitude and mix from the updated phases, using gate
         // and wave_sel as they stand now; output holds between valids.
         vld_p1 <= vld_p0;
         if (vld_p0)
            sample_p1 <= amp(acc0_p0, bus.gate[0], bus.wave_sel[0])
                       + amp(acc1_p0, bus.gate[1], bus.wave_sel[1]);
      end
   end

   assign bus.sample_out   = sample_p1;
   assign bus.sample_valid = vld_p1;
   assign bus.wrap         = wrap_p0;

endmodule

// File: tb/tb_voice_phase_acc.sv
// ---------------------------------------------------------------------------
// tb_voice_phase_acc
// Randomized and directed bench for voice_phase_acc with a behavioural
// phase/mix model; outputs compared every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_voice_phase_acc;

   localparam int M = 12;
   localparam int N = 16;
   localparam int W = 8;
   localparam int PMOD = 1 << N;

   logic clk = 1'b0;
   logic rst_n;

   voice_phase_acc_if #(.M(M), .W(W)) bus ();

   voice_phase_acc #(.M(M), .N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         ph  [2];
   int         twm [2];
   bit         pend;
   bit         model_live = 1'b0;
   logic       exp_valid;
   logic [7:0] exp_out;
   logic [1:0] exp_wrap;

   function automatic int amp_m(input int phase, input bit g, input bit sq);
      if (!g) return 0;
      if (sq) return (phase >= PMOD / 2) ? (1 << (W - 1)) - 1 : 0;
      return phase / (1 << (N - W + 1));
   endfunction

   always @(posedge clk) begin
      int sum;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            ph[i]  = 0;
            twm[i] = 0;
         end
         pend       = 1'b0;
         exp_valid  = 1'b0;
         exp_out    = '0;
         exp_wrap   = '0;
         model_live = 1'b1;
      end else begin
         exp_valid = pend;
         if (pend)
            exp_out = 8'(amp_m(ph[0], bus.gate[0], bus.wave_sel[0])
                       + amp_m(ph[1], bus.gate[1], bus.wave_sel[1]));
         for (int i = 0; i < 2; i++) begin
            if (!bus.gate[i]) begin
               ph[i]       = 0;
               exp_wrap[i] = 1'b0;
            end else if (bus.sample_tick) begin
               sum         = ph[i] + twm[i];
               exp_wrap[i] = (sum >= PMOD);
               ph[i]       = sum % PMOD;
            end else begin
               exp_wrap[i] = 1'b0;
            end
         end
         if (bus.tw_load[0]) twm[0] = int'(bus.tw0);
         if (bus.tw_load[1]) twm[1] = int'(bus.tw1);
         pend = bus.sample_tick;
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         check("sample_valid", 32'(bus.sample_valid), 32'(exp_valid));
         check("sample_out",   32'(bus.sample_out),   32'(exp_out));
         check("wrap",         32'(bus.wrap),         32'(exp_wrap));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit r, input bit tick, input logic [1:0] load,
                       input logic [1:0] g, input logic [1:0] ws,
                       input logic [11:0] t0, input logic [11:0] t1);
      rst_n           = r;
      bus.sample_tick = tick;
      bus.tw_load     = load;
      bus.gate        = g;
      bus.wave_sel    = ws;
      bus.tw0         = t0;
      bus.tw1         = t1;
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      int first;
      int last;

      // Reset with random inputs
      for (int i = 0; i < 2; i++)
         step(1'b0, 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
              12'($urandom), 12'($urandom));
      check("rst_out",   32'(bus.sample_out),   32'h00);
      check("rst_valid", 32'(bus.sample_valid), 32'h0);
      check("rst_wrap",  32'(bus.wrap),         32'h0);

      // Saw on voice 0
      step(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 12'h400, 12'h000);
      step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("saw1_valid", 32'(bus.sample_valid), 32'h1);
      check("saw1_out",   32'(bus.sample_out),   32'h02);
      check("model_saw1", 32'(exp_out),          32'h02);
      for (int i = 0; i < 31; i++)
         step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("saw32_out", 32'(bus.sample_out), 32'h40);
      for (int i = 0; i < 31; i++)
         step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("saw63_nowrap", 32'(bus.wrap), 32'h0);
      step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("saw64_wrap", 32'(bus.wrap), 32'h1);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("saw64_wrap_end", 32'(bus.wrap),       32'h0);
      check("saw64_out",      32'(bus.sample_out), 32'h00);

      // Square mix on both voices
      step(1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 12'h400, 12'h400);
      for (int i = 0; i < 32; i++)
         step(1'b1, 1'b1, 2'b00, 2'b11, 2'b11, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b11, 2'b11, 12'h000, 12'h000);
      check("sq_mix_out", 32'(bus.sample_out), 32'hFE);
      check("model_sq",   32'(exp_out),        32'hFE);
      step(1'b1, 1'b1, 2'b00, 2'b01, 2'b11, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b11, 12'h000, 12'h000);
      check("sq_gate01_out", 32'(bus.sample_out), 32'h7F);

      // Load/tick collision
      step(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 12'h400, 12'h000);
      step(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 12'h800, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("collide_old_tw", 32'(bus.sample_out), 32'h02);
      step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("collide_new_tw", 32'(bus.sample_out), 32'h06);

      // Back-to-back ticks
      cnt = 0; first = -1; last = -1;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i < 5), 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
         if (bus.sample_valid === 1'b1) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      check("b2b_count", 32'(cnt),   32'd5);
      check("b2b_first", 32'(first), 32'd1);
      check("b2b_last",  32'(last),  32'd5);

      // Reset mid-operation
      step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      step(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("midrst_valid", 32'(bus.sample_valid), 32'h0);
      check("midrst_out",   32'(bus.sample_out),   32'h00);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("midrst_dropped", 32'(bus.sample_valid), 32'h0);
      step(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 12'h400, 12'h000);
      step(1'b1, 1'b1, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 12'h000, 12'h000);
      check("midrst_first_out", 32'(bus.sample_out), 32'h02);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 2) != 0),
              (($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00),
              (($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b11),
              2'($urandom),
              12'($urandom), 12'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
